reg_bank16: RTL
===============

// Module: reg_bank16
// PURPOSE
//  16 x 16-bit general-purpose register bank of the RISC core; sits directly upstream of the read-select mux stage.
//  Holds the architectural registers, accepts one write per clock, and serves two combinational read ports (A, B).
//  Each read port selects through a read-mux sub-module, with optional write-to-read bypass.
//  A per-register busy scoreboard lets decode stall on operands whose producer has issued but not yet written back.
// PARAMETERS
//  DW      16  data width of each register
//  AW      4   address width (2**AW = 16 registers)
//  BYPASS  1   1: a same-cycle write is forwarded to a matching read port; 0: read returns the stored value
//  ZERO_R0 0   1: R0 reads as 0, writes to R0 are dropped, R0 is never busy
// PORTS
//  clk        in   1   core clock, all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  wr_en      in   1   write-back strobe
//  wr_addr    in   AW  write-back register index
//  wr_data    in   DW  write-back data
//  iss_en     in   1   instruction issued that will write iss_addr (sets busy)
//  iss_addr   in   AW  destination register of issued instruction
//  rd_a_addr  in   AW  read port A index
//  rd_a_data  out  DW  read port A data (combinational)
//  rd_a_busy  out  1   port A operand not yet available
//  rd_b_addr  in   AW  read port B index
//  rd_b_data  out  DW  read port B data (combinational)
//  rd_b_busy  out  1   port B operand not yet available
//  busy_vec   out  16  scoreboard state, bit i = register i busy
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers <= 0, busy_vec <= 0; so rd_*_data=0 and rd_*_busy=0 while reset is held.
//  - Write: wr_en=1 at rising edge -> reg[wr_addr] <= wr_data; visible on reads from the next cycle (0-cycle with BYPASS).
//  - Read: rd_x_data = (BYPASS & wr_en & wr_addr==rd_x_addr) ? wr_data : reg[rd_x_addr]; pure combinational, no latency.
//  - Both ports may read the same index; both return the same value.
//  - Scoreboard, per register i, at rising edge:
//      set = iss_en & iss_addr==i; clr = wr_en & wr_addr==i
//      set & ~clr -> busy[i]<=1; clr & ~set -> busy[i]<=0; set & clr -> busy[i]<=1 (new producer wins); else hold.
//  - rd_x_busy = busy[rd_x_addr] & ~(BYPASS & wr_en & wr_addr==rd_x_addr); with BYPASS=0 a register stays busy
//    in the write-back cycle itself and clears the next cycle.
//  - Write to a non-busy register is legal (no error); busy stays 0.
//  - Issue to an already-busy register is legal; busy stays 1 and the first write-back clears it
//    (in-order single write-back only).
//  - ZERO_R0=1: index 0 ignores wr_en/iss_en, reads 0, busy_vec[0]=0, and no bypass applies for index 0.
//  - Reset asserted mid-operation clears all state immediately; a write in the release edge's cycle is lost.
//  - Widths are fixed; no truncation or extension inside the block.
// STRUCTURE
//  - Shared package: DW/AW defaults, REG_COUNT=16, register-index typedef, R0 index constant.
//  - Sub-module reg_read_mux: 16:1 x DW combinational select by AW-bit index; instantiated twice (ports A, B).
//    It has a full case with an explicit default of 0.
//  - Top: register array + write decode, scoreboard flops, bypass compare and busy logic.
// TESTING
//  1. rst_n=0 mid-run after writes -> all rd_*_data=0, busy_vec=0 immediately (no clock needed).
//  2. write R5=16'hA5A5, next cycle rd_a_addr=5, rd_b_addr=5 -> both ports return 16'hA5A5.
//  3. BYPASS=1: wr_en, wr_addr=3, wr_data=16'h1234, rd_a_addr=3 same cycle -> rd_a_data=16'h1234, rd_a_busy=0.
//     BYPASS=0: same stimulus -> old R3 value is returned.
//  4. iss R7 -> busy_vec=16'h0080, rd_b_busy=1 for rd_b_addr=7; write R7 two cycles later -> busy clears, data updates.
//  5. Same edge: iss_addr=9 and wr_addr=9 -> busy[9]=1 after the edge, reg[9] holds the written data.
//  6. ZERO_R0=1: write R0=16'hFFFF and iss R0 -> rd_a_data=0, busy_vec[0]=0. Sweep all 16 indices on both ports.

Source files
------------

// File: rtl/reg_bank16_pkg.sv
// Shared definitions for the general-purpose register bank: default widths,
// register count, register-index type and the R0 index constant.
package reg_bank16_pkg;

  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 4;
  localparam int REG_COUNT = 16;

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam reg_idx_t R0_IDX = '0;

endpackage : reg_bank16_pkg

// File: rtl/reg_read_mux.sv
// 16:1 combinational read select used by each read port of the register bank.
module reg_read_mux
  import reg_bank16_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] regs_i [REG_COUNT],
  input  reg_idx_t      sel_i,
  output logic [DW-1:0] data_o
);

  // Pure select; an out-of-table index (not reachable at AW=4) reads as zero.
  always_comb begin
    data_o = '0;
    case (sel_i)
      4'd0:    data_o = regs_i[0];
      4'd1:    data_o = regs_i[1];
      4'd2:    data_o = regs_i[2];
      4'd3:    data_o = regs_i[3];
      4'd4:    data_o = regs_i[4];
      4'd5:    data_o = regs_i[5];
      4'd6:    data_o = regs_i[6];
      4'd7:    data_o = regs_i[7];
      4'd8:    data_o = regs_i[8];
      4'd9:    data_o = regs_i[9];
      4'd10:   data_o = regs_i[10];
      4'd11:   data_o = regs_i[11];
      4'd12:   data_o = regs_i[12];
      4'd13:   data_o = regs_i[13];
      4'd14:   data_o = regs_i[14];
      4'd15:   data_o = regs_i[15];
      default: data_o = '0;
    endcase
  end

endmodule : reg_read_mux

// File: rtl/reg_bank16.sv
// 16 x 16-bit architectural register bank: one write port, two combinational
// read ports with optional write-to-read bypass, and a per-register busy
// scoreboard (set on issue, cleared on write-back, issue wins on collision).
// busy_vec exposes the scoreboard state directly for checkers.
module reg_bank16
  import reg_bank16_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [AW-1:0]        rd_a_addr,
  output logic [DW-1:0]        rd_a_data,
  output logic                 rd_a_busy,
  input  logic [AW-1:0]        rd_b_addr,
  output logic [DW-1:0]        rd_b_data,
  output logic                 rd_b_busy,
  output logic [REG_COUNT-1:0] busy_vec
);

  // With ZERO_R0 the R0 bit is masked out of every write and scoreboard update.
  localparam logic [REG_COUNT-1:0] KEEP_MASK =
    ZERO_R0 ? ~REG_COUNT'(1) : {REG_COUNT{1'b1}};

  logic [DW-1:0]        regs_q [REG_COUNT];
  logic [DW-1:0]        regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [REG_COUNT-1:0] set_v, clr_v;
  logic                 wr_drop;
  logic [DW-1:0]        mux_a, mux_b;
  logic                 byp_a, byp_b;

  assign wr_drop = ZERO_R0 && (wr_addr == R0_IDX);

  // Write decode: only the addressed register takes the write-back data.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && !wr_drop) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Register array; asynchronous reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Scoreboard next state: a new producer (set) beats a write-back (clr).
  always_comb begin
    set_v  = iss_en ? (REG_COUNT'(1) << iss_addr) : '0;
    clr_v  = wr_en  ? (REG_COUNT'(1) << wr_addr)  : '0;
    busy_d = (set_v | (busy_q & ~clr_v)) & KEEP_MASK;
  end

  // Scoreboard flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  reg_read_mux #(.DW(DW)) u_mux_a (
    .regs_i (regs_q),
    .sel_i  (rd_a_addr),
    .data_o (mux_a)
  );

  reg_read_mux #(.DW(DW)) u_mux_b (
    .regs_i (regs_q),
    .sel_i  (rd_b_addr),
    .data_o (mux_b)
  );

  // Bypass match per port; suppressed for R0 when it is hard-wired to zero and
  // while reset is held so reads stay zero regardless of wr_en.
  always_comb begin
    byp_a = BYPASS && rst_n && wr_en && (wr_addr == rd_a_addr)
            && !(ZERO_R0 && (rd_a_addr == R0_IDX));
    byp_b = BYPASS && rst_n && wr_en && (wr_addr == rd_b_addr)
            && !(ZERO_R0 && (rd_b_addr == R0_IDX));
  end

  // Read data and operand-busy per port.
  always_comb begin
    rd_a_data = byp_a ? wr_data : mux_a;
    rd_b_data = byp_b ? wr_data : mux_b;
    rd_a_busy = busy_q[rd_a_addr] & ~byp_a;
    rd_b_busy = busy_q[rd_b_addr] & ~byp_b;
  end

endmodule : reg_bank16
